// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a 1W/1R RAM with registered read.
// Optional power-on clear of the whole RAM is enabled with `define RAM_ARB_INIT_EN.
module ram_rr_arbiter #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic               a_write,
  input  logic [A_WIDTH-1:0] a_addr,
  input  logic [D_WIDTH-1:0] a_wdata,
  output logic               a_ready,
  output logic               a_rsp_valid,
  output logic [D_WIDTH-1:0] a_rsp_data,
  input  logic               b_valid,
  input  logic               b_write,
  input  logic [A_WIDTH-1:0] b_addr,
  input  logic [D_WIDTH-1:0] b_wdata,
  output logic               b_ready,
  output logic               b_rsp_valid,
  output logic [D_WIDTH-1:0] b_rsp_data,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read,
  output logic               init_busy
);

  typedef enum logic {S_INIT, S_RUN} state_e;
  typedef enum logic {OWN_A, OWN_B} owner_e;

`ifdef RAM_ARB_INIT_EN
  localparam state_e RESET_STATE = S_INIT;
`else
  localparam state_e RESET_STATE = S_RUN;
`endif

  state_e             state_q, state_d;
  owner_e             ptr_q, ptr_d;
  logic               rsp_a_q, rsp_a_d;
  logic               rsp_b_q, rsp_b_d;
  logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic               run;
  logic               grant_a, grant_b, xfer;
  logic               sel_write, wr_grant, rd_grant;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wdata;

`ifdef RAM_ARB_INIT_EN
  logic [A_WIDTH-1:0] init_addr_q, init_addr_d;
  logic               init_we;
`endif

  // Grants are masked while rst is high so nothing reaches the RAM during reset.
  assign run     = (state_q == S_RUN) && !rst;
  assign grant_a = run && a_valid && (!b_valid || ptr_q == OWN_A);
  assign grant_b = run && b_valid && (!a_valid || ptr_q == OWN_B);
  assign xfer    = grant_a || grant_b;

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign sel_write = grant_a ? a_write : b_write;
  assign sel_addr  = grant_a ? a_addr  : b_addr;
  assign sel_wdata = grant_a ? a_wdata : b_wdata;
  assign wr_grant  = xfer && sel_write;
  assign rd_grant  = xfer && !sel_write;

  assign ram_address_read = rd_grant ? sel_addr : rd_addr_q;

`ifdef RAM_ARB_INIT_EN
  assign init_we           = (state_q == S_INIT) && !rst;
  assign ram_write_enable  = init_we || wr_grant;
  assign ram_address_write = init_we ? init_addr_q : sel_addr;
  assign ram_data_write    = init_we ? '0 : sel_wdata;
  assign init_busy         = (state_q == S_INIT);
`else
  assign ram_write_enable  = wr_grant;
  assign ram_address_write = sel_addr;
  assign ram_data_write    = sel_wdata;
  assign init_busy         = 1'b0;
`endif

  // A response registered before reset is suppressed in the reset cycle itself.
  assign a_rsp_valid = rsp_a_q && !rst;
  assign b_rsp_valid = rsp_b_q && !rst;
  assign a_rsp_data  = a_rsp_valid ? ram_data_read : '0;
  assign b_rsp_data  = b_rsp_valid ? ram_data_read : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    rd_addr_d = rd_addr_q;
    rsp_a_d   = grant_a && !a_write;
    rsp_b_d   = grant_b && !b_write;
    if (xfer) begin
      ptr_d = grant_a ? OWN_B : OWN_A;
    end
    if (rd_grant) begin
      rd_addr_d = sel_addr;
    end
`ifdef RAM_ARB_INIT_EN
    init_addr_d = init_addr_q;
    if (state_q == S_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (&init_addr_q) begin
        state_d = S_RUN;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= RESET_STATE;
      ptr_q     <= OWN_A;
      rsp_a_q   <= 1'b0;
      rsp_b_q   <= 1'b0;
      rd_addr_q <= '0;
`ifdef RAM_ARB_INIT_EN
      init_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rsp_a_q   <= rsp_a_d;
      rsp_b_q   <= rsp_b_d;
      rd_addr_q <= rd_addr_d;
`ifdef RAM_ARB_INIT_EN
      init_addr_q <= init_addr_d;
`endif
    end
  end

endmodule
